// File: rtl/spi_master_mode3.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), MSB first, running bursts of full-duplex words.
// Handshake: start/busy/done for the burst, tx_ack per loaded word, rx_valid per received word.
module spi_master_mode3 #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int BURST_W    = 8
) (
    input  logic                  mainclk,
    input  logic                  rstb,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  sck,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BURST_W-1:0] ONE_WORD = BURST_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [DIV_W-1:0]      div_reg, div_next;
    logic [BIT_W-1:0]      bit_reg, bit_next;
    logic [BURST_W-1:0]    word_reg, word_next;
    logic [DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic [DATA_WIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
    logic                  rx_valid_reg, rx_valid_next;
    logic                  tx_ack_reg, tx_ack_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  sck_reg, sck_next;
    logic                  ss_n_reg, ss_n_next;
    logic                  mosi_reg, mosi_next;

    logic                  div_last;
    logic                  sample_edge;
    logic [DATA_WIDTH-1:0] rx_sample;

    assign div_last    = (div_reg == DIV_LAST);
    // The LOW->HIGH edge both raises sck and captures miso.
    assign sample_edge = (state_reg == LOW) && div_last;
    assign rx_sample   = {rx_shift_reg[DATA_WIDTH-2:0], miso};

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        bit_next      = bit_reg;
        word_next     = word_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        tx_ack_next   = 1'b0;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        sck_next      = sck_reg;
        ss_n_next     = ss_n_reg;
        mosi_next     = mosi_reg;

        if (sample_edge) begin
            rx_shift_next = rx_sample;
            if (bit_reg == BIT_LAST) begin
                rx_data_next  = rx_sample;
                rx_valid_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (start && (burst_len != '0)) begin
                    state_next    = SETUP;
                    div_next      = '0;
                    bit_next      = '0;
                    word_next     = burst_len;
                    tx_shift_next = tx_data;
                    mosi_next     = tx_data[DATA_WIDTH-1];
                    tx_ack_next   = 1'b1;
                    busy_next     = 1'b1;
                    ss_n_next     = 1'b0;
                    sck_next      = 1'b1;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_next = LOW;
                    div_next   = '0;
                    sck_next   = 1'b0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            LOW: begin
                if (div_last) begin
                    state_next = HIGH;
                    div_next   = '0;
                    sck_next   = 1'b1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_next = '0;
                    if (bit_reg != BIT_LAST) begin
                        // Falling edge inside a word: present the next bit.
                        state_next    = LOW;
                        sck_next      = 1'b0;
                        bit_next      = bit_reg + 1'b1;
                        tx_shift_next = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
                        mosi_next     = tx_shift_reg[DATA_WIDTH-2];
                    end else begin
                        bit_next  = '0;
                        word_next = word_reg - 1'b1;
                        if (word_reg != ONE_WORD) begin
                            // Back-to-back word: load and go straight to LOW.
                            state_next    = LOW;
                            sck_next      = 1'b0;
                            tx_shift_next = tx_data;
                            mosi_next     = tx_data[DATA_WIDTH-1];
                            tx_ack_next   = 1'b1;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_next = IDLE;
                    div_next   = '0;
                    ss_n_next  = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    mosi_next  = 1'b1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ss_n_next  = 1'b1;
                sck_next   = 1'b1;
                mosi_next  = 1'b1;
                busy_next  = 1'b0;
            end
        endcase

        // Abort overrides everything except a word completing on this very edge.
        if (abort && (state_reg != IDLE)) begin
            state_next  = IDLE;
            div_next    = '0;
            bit_next    = '0;
            word_next   = '0;
            tx_ack_next = 1'b0;
            sck_next    = 1'b1;
            ss_n_next   = 1'b1;
            mosi_next   = 1'b1;
            busy_next   = 1'b0;
            done_next   = 1'b1;
        end
    end

    always_ff @(posedge mainclk or negedge rstb) begin
        if (!rstb) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            bit_reg      <= '0;
            word_reg     <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            tx_ack_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sck_reg      <= 1'b1;
            ss_n_reg     <= 1'b1;
            mosi_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            bit_reg      <= bit_next;
            word_reg     <= word_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            tx_ack_reg   <= tx_ack_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            sck_reg      <= sck_next;
            ss_n_reg     <= ss_n_next;
            mosi_reg     <= mosi_next;
        end
    end

    assign tx_ack   = tx_ack_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sck      = sck_reg;
    assign ss_n     = ss_n_reg;
    assign mosi     = mosi_reg;

endmodule

// File: tb/tb_spi_master_mode3.sv
// Directed bench for spi_master_mode3: CLK_DIV=2 and CLK_DIV=1 instances, mode-3 slave model,
// cycle-exact handshake checks.
module tb_spi_master_mode3;

    logic        mainclk = 1'b0;
    logic        rstb;
    logic        start, abort, sel;
    logic [7:0]  burst_len, tx_data;
    logic        miso;

    logic        tx_ack_a, rx_valid_a, busy_a, done_a, sck_a, ss_n_a, mosi_a;
    logic [7:0]  rx_data_a;
    logic        tx_ack_b, rx_valid_b, busy_b, done_b, sck_b, ss_n_b, mosi_b;
    logic [7:0]  rx_data_b;

    logic        m_tx_ack, m_rx_valid, m_busy, m_done, m_sck, m_ss_n, m_mosi;
    logic [7:0]  m_rx_data;

    always #5 mainclk = ~mainclk;

    spi_master_mode3 #(.DATA_WIDTH(8), .CLK_DIV(2), .BURST_W(8)) dut_a (
        .mainclk(mainclk), .rstb(rstb), .start(start && !sel), .abort(abort && !sel),
        .burst_len(burst_len), .tx_data(tx_data), .tx_ack(tx_ack_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .busy(busy_a), .done(done_a), .sck(sck_a), .ss_n(ss_n_a),
        .mosi(mosi_a), .miso(miso)
    );

    spi_master_mode3 #(.DATA_WIDTH(8), .CLK_DIV(1), .BURST_W(8)) dut_b (
        .mainclk(mainclk), .rstb(rstb), .start(start && sel), .abort(abort && sel),
        .burst_len(burst_len), .tx_data(tx_data), .tx_ack(tx_ack_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .busy(busy_b), .done(done_b), .sck(sck_b), .ss_n(ss_n_b),
        .mosi(mosi_b), .miso(miso)
    );

    assign m_tx_ack   = sel ? tx_ack_b   : tx_ack_a;
    assign m_rx_valid = sel ? rx_valid_b : rx_valid_a;
    assign m_busy     = sel ? busy_b     : busy_a;
    assign m_done     = sel ? done_b     : done_a;
    assign m_sck      = sel ? sck_b      : sck_a;
    assign m_ss_n     = sel ? ss_n_b     : ss_n_a;
    assign m_mosi     = sel ? mosi_b     : mosi_a;
    assign m_rx_data  = sel ? rx_data_b  : rx_data_a;

    // Monitor and mode-3 slave: slave shifts out on sck falling edges, MSB first.
    int          n_ss = 0, n_busy = 0, n_ack = 0, n_valid = 0, n_done = 0, n_fall = 0;
    int          slave_cnt = 0;
    logic [31:0] mosi_hist = '0, rx_hist = '0, slave_pat = '0;
    logic        prev_sck = 1'b1;

    always @(negedge mainclk) begin
        if (!m_ss_n) n_ss++;
        if (m_busy) n_busy++;
        if (m_tx_ack) n_ack++;
        if (m_done) n_done++;
        if (m_rx_valid) begin
            n_valid++;
            rx_hist = {rx_hist[23:0], m_rx_data};
        end
        if (m_ss_n) begin
            slave_cnt = 0;
        end else if (prev_sck && !m_sck) begin
            n_fall++;
            mosi_hist = {mosi_hist[30:0], m_mosi};
            if (slave_cnt < 32) miso = slave_pat[31 - slave_cnt];
            slave_cnt++;
        end
        prev_sck = m_sck;
    end

    int total = 0, bad = 0;
    int s_ss, s_busy, s_ack, s_valid, s_done, s_fall;
    int dc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic snap();
        s_ss = n_ss; s_busy = n_busy; s_ack = n_ack;
        s_valid = n_valid; s_done = n_done; s_fall = n_fall;
    endtask

    task automatic result(input string tag, input int got_dc, input int e_dc, input int e_ss,
                          input int e_ack, input int e_valid, input int e_done, input int e_fall);
        chk({tag, ".done_cyc"}, got_dc, e_dc);
        chk({tag, ".ss_low"}, n_ss - s_ss, e_ss);
        chk({tag, ".busy_cyc"}, n_busy - s_busy, e_ss);
        chk({tag, ".tx_ack"}, n_ack - s_ack, e_ack);
        chk({tag, ".rx_valid"}, n_valid - s_valid, e_valid);
        chk({tag, ".done_cnt"}, n_done - s_done, e_done);
        chk({tag, ".sck_fall"}, n_fall - s_fall, e_fall);
    endtask

    // Word i of txw is txw[31-8i -: 8]; cycle 1 is the first cycle after the start edge.
    task automatic xfer(input int n, input logic [31:0] txw, input int abort_at, input int restart_at,
                        input int rst_at, input logic with_abort, input int max, output int done_cyc);
        int k;
        k = 1;
        done_cyc = -1;
        tx_data = txw[31:24];
        burst_len = 8'(n);
        start = 1'b1;
        abort = with_abort;
        for (int c = 1; c <= max; c++) begin
            @(negedge mainclk);
            start = (c == restart_at);
            abort = (c == abort_at);
            if (c == 1) begin
                chk("c1.ss_n", m_ss_n, 1'b0);
                chk("c1.busy", m_busy, 1'b1);
                chk("c1.tx_ack", m_tx_ack, 1'b1);
                chk("c1.mosi", m_mosi, txw[31]);
            end
            if (m_tx_ack && k < n) begin
                tx_data = txw[31 - 8*k -: 8];
                k++;
            end
            if (c == rst_at) begin
                rstb = 1'b0;
                #1;
                chk("rst.sck", m_sck, 1'b1);
                chk("rst.ss_n", m_ss_n, 1'b1);
                chk("rst.busy", m_busy, 1'b0);
                chk("rst.mosi", m_mosi, 1'b1);
                chk("rst.rx_data", m_rx_data, 8'h00);
                repeat (2) @(negedge mainclk);
                chk("rst.done", m_done, 1'b0);
                rstb = 1'b1;
                break;
            end
            if (m_done) begin
                done_cyc = c;
                if (abort_at > 0) begin
                    chk("abort.ss_n", m_ss_n, 1'b1);
                    chk("abort.sck", m_sck, 1'b1);
                    chk("abort.busy", m_busy, 1'b0);
                    chk("abort.mosi", m_mosi, 1'b1);
                end
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        sel = 1'b0; rstb = 1'b0; start = 1'b0; abort = 1'b0;
        burst_len = '0; tx_data = '0; miso = 1'b1;
        repeat (3) @(negedge mainclk);
        chk("reset.sck", m_sck, 1'b1);
        chk("reset.ss_n", m_ss_n, 1'b1);
        chk("reset.mosi", m_mosi, 1'b1);
        chk("reset.busy", m_busy, 1'b0);
        chk("reset.done", m_done, 1'b0);
        chk("reset.tx_ack", m_tx_ack, 1'b0);
        chk("reset.rx_valid", m_rx_valid, 1'b0);
        chk("reset.rx_data", m_rx_data, 8'h00);
        rstb = 1'b1;
        repeat (2) @(negedge mainclk);

        // Single word
        slave_pat = 32'h3C00_0000;
        snap();
        xfer(1, 32'hA500_0000, 0, 0, 0, 1'b0, 200, dc);
        repeat (4) @(negedge mainclk);
        result("s1", dc, 37, 36, 1, 1, 1, 8);
        chk("s1.rx", rx_hist[7:0], 8'h3C);
        chk("s1.mosi", mosi_hist[7:0], 8'hA5);

        // Three-word burst
        slave_pat = 32'hC1C2_C300;
        snap();
        xfer(3, 32'h1122_3300, 0, 0, 0, 1'b0, 400, dc);
        repeat (4) @(negedge mainclk);
        result("s2", dc, 101, 100, 3, 3, 1, 24);
        chk("s2.rx", rx_hist[23:0], 24'hC1C2C3);
        chk("s2.mosi", mosi_hist[23:0], 24'h112233);

        // Abort during bit 4 of word 2 (LOW half of that bit spans cycles 51..52)
        snap();
        xfer(3, 32'hAABB_CC00, 52, 0, 0, 1'b0, 400, dc);
        repeat (20) @(negedge mainclk);
        result("s3", dc, 53, 52, 2, 1, 1, 13);
        chk("s3.rx", rx_hist[7:0], 8'hC1);

        // Start while busy is ignored; start with burst_len=0 and abort in IDLE do nothing
        slave_pat = 32'h3C00_0000;
        snap();
        xfer(1, 32'hA500_0000, 0, 10, 0, 1'b0, 200, dc);
        repeat (4) @(negedge mainclk);
        result("s4", dc, 37, 36, 1, 1, 1, 8);
        snap();
        burst_len = 8'd0; start = 1'b1;
        @(negedge mainclk);
        start = 1'b0; abort = 1'b1;
        @(negedge mainclk);
        abort = 1'b0;
        repeat (5) @(negedge mainclk);
        chk("s4.idle_ss_n", m_ss_n, 1'b1);
        chk("s4.idle_busy", m_busy, 1'b0);
        chk("s4.idle_ack", n_ack - s_ack, 0);
        chk("s4.idle_done", n_done - s_done, 0);
        chk("s4.idle_ss_cnt", n_ss - s_ss, 0);

        // Reset mid-word, then a clean single-word transfer
        snap();
        xfer(1, 32'hA500_0000, 0, 0, 20, 1'b0, 200, dc);
        repeat (2) @(negedge mainclk);
        chk("s5.no_done", n_done - s_done, 0);
        chk("s5.no_valid", n_valid - s_valid, 0);
        snap();
        xfer(1, 32'hA500_0000, 0, 0, 0, 1'b0, 200, dc);
        repeat (4) @(negedge mainclk);
        result("s5", dc, 37, 36, 1, 1, 1, 8);
        chk("s5.rx", rx_hist[7:0], 8'h3C);
        chk("s5.mosi", mosi_hist[7:0], 8'hA5);

        // CLK_DIV=1 instance, started with abort raised in the same IDLE cycle
        sel = 1'b1;
        slave_pat = 32'hE718_0000;
        repeat (2) @(negedge mainclk);
        snap();
        xfer(2, 32'h5A96_0000, 0, 0, 0, 1'b1, 200, dc);
        repeat (4) @(negedge mainclk);
        result("s6", dc, 35, 34, 2, 2, 1, 16);
        chk("s6.rx", rx_hist[15:0], 16'hE718);
        chk("s6.mosi", mosi_hist[15:0], 16'h5A96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_mode3.md
Name: spi_master_mode3

Overview:
- SPI master, mode 3 (CPOL=1, CPHA=1), MSB first. It is the initiator side of the 4-wire sample-readout link that the FPGA's SPI slave serves.
- Used by the bench and by the host-emulation board to clock ADC sample bytes out of the slave while sending command bytes on mosi.
- Runs bursts of N full-duplex words under a start/busy/done handshake, with a per-word tx load acknowledge and an rx valid strobe.

Parameters:
DATA_WIDTH, 8, bits per SPI word
CLK_DIV, 2, mainclk cycles per sck half-period (>=1)
BURST_W, 8, width of burst_len

Ports:
mainclk  in  1  system clock; all logic on rising edge
rstb  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  synchronous; terminates the transaction
burst_len  in  BURST_W  number of words; latched with start
tx_data  in  DATA_WIDTH  next word to send; latched at each word load
tx_ack  out  1  one-cycle pulse: tx_data was latched in the previous edge
rx_data  out  DATA_WIDTH  last complete received word
rx_valid  out  1  one-cycle pulse, rx_data new
busy  out  1  high from first cycle after accepted start until done
done  out  1  one-cycle pulse at transaction end
sck  out  1  SPI clock, idles high
ss_n  out  1  slave select, active low
mosi  out  1  master out
miso  in  1  master in

Behaviour:
- Reset (rstb=0, async): state IDLE, sck=1, ss_n=1, mosi=1, busy=0, done=0, tx_ack=0, rx_valid=0, rx_data=0, all counters 0. Reset mid-transaction aborts immediately; no done pulse.
- States: IDLE, SETUP, LOW, HIGH, HOLD.
- IDLE -> SETUP: start=1 and burst_len!=0 at edge E0.
  - At E0: latch burst_len and tx_data.
  - From the next cycle (cycle 1): ss_n=0, busy=1, tx_ack=1 for one cycle, mosi=tx_data[MSB].
- Start ignored when burst_len=0 or when not in IDLE (no state change, no pulses).
- SETUP: lasts CLK_DIV cycles with sck=1, then -> LOW.
- LOW: sck=0 for CLK_DIV cycles.
  - Entering LOW (falling edge): mosi shifts to the next bit. The first bit of each word was already placed at word load.
  - End of LOW -> HIGH.
- HIGH: sck=1 for CLK_DIV cycles.
  - Entering HIGH (rising edge): miso is registered into the rx shift register in the same mainclk edge that drives sck 0->1.
  - After the last bit's sample edge: rx_data is updated and rx_valid=1 for the following single cycle.
- End of HIGH:
  - Bit not last -> LOW.
  - Last bit, more words remaining -> latch tx_data, tx_ack pulse, mosi=new MSB, -> LOW. ss_n stays low; no gap between words.
  - Last bit of last word -> HOLD.
- HOLD: CLK_DIV cycles with sck=1 and ss_n=0. Then -> IDLE with ss_n=1, busy=0, and done=1 for that one cycle.
- Timing: ss_n low for exactly CLK_DIV*(2 + 2*DATA_WIDTH*burst_len) cycles.
- Abort in SETUP/LOW/HIGH/HOLD:
  - Next cycle: sck=1, ss_n=1, mosi=1, busy=0, done=1, state IDLE.
  - A partially received word produces no rx_valid. If abort coincides with the last-bit sample edge, that word's rx_valid is still issued.
  - Abort in IDLE has no effect.
  - If abort and start occur together in IDLE, start wins.
- Counters: bit counter 0..DATA_WIDTH-1; word counter counts down from burst_len to 0 with no wrap; burst_len is all-ones-safe.
- sck, ss_n and mosi are registered outputs (glitch-free).
- tx_data must be stable only at load edges. The caller has 2*CLK_DIV*DATA_WIDTH cycles after tx_ack to present the next word.

Test Plan:
1. CLK_DIV=2, DATA_WIDTH=8, burst_len=1, tx_data=0xA5, slave model returns 0x3C.
   - mosi bits on successive falling edges = 1,0,1,0,0,1,0,1; 8 sck low pulses of 2 cycles each.
   - ss_n low for cycles 1..36; rx_data=0x3C with one rx_valid; done=1 at cycle 37; busy 1..36.
2. burst_len=3, tx_data 0x11/0x22/0x33 supplied after each tx_ack, slave returns 0xC1/0xC2/0xC3.
   - Exactly 3 tx_ack and 3 rx_valid pulses with matching rx_data.
   - 24 sck pulses with ss_n continuously low for 100 cycles; single done pulse.
3. abort asserted during bit 4 of word 2 of a 3-word burst.
   - Next cycle: ss_n=1, sck=1, done=1, busy=0.
   - Only one rx_valid seen in total; no further sck edges.
4. start pulsed while busy, and start with burst_len=0 in IDLE.
   - No state change, no ss_n change, no tx_ack/done.
5. rstb driven low mid-word.
   - Asynchronously: sck=1, ss_n=1, busy=0, rx_data=0, no done.
   - After release, a new single-word transfer matches scenario 1 exactly.
6. CLK_DIV=1, burst_len=2.
   - sck toggles every cycle; ss_n low for exactly 34 cycles.
   - Both words received correctly; abort and start in the same IDLE cycle starts a transfer.
